ex_muldiv: RTL
==============

Name: ex_muldiv

Overview:
- HI/LO multiply/divide unit at the EX end of the ID/EX pipeline register.
- Consumes the registered operand pair (readData1 = rs, readData2 = rt) and the instruction code from ID/EX.
- Executes MULT/MULTU/DIV/DIVU iteratively, MTHI/MTLO directly, and supplies MFHI/MFLO read data.
- Drives a stall back to the ID/EX register while a HI/LO access must wait.

Parameters:
- OP_MULT, 8'h20, inst_name code for MULT
- OP_MULTU, 8'h21, inst_name code for MULTU
- OP_DIV, 8'h22, inst_name code for DIV
- OP_DIVU, 8'h23, inst_name code for DIVU
- OP_MFHI, 8'h24, inst_name code for MFHI
- OP_MFLO, 8'h25, inst_name code for MFLO
- OP_MTHI, 8'h26, inst_name code for MTHI
- OP_MTLO, 8'h27, inst_name code for MTLO

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  EX slot holds a valid instruction
- inst_name  in  8  instruction code from ID/EX
- readData1  in  32  rs operand
- readData2  in  32  rt operand
- flush  in  1  abandon the in-flight operation (exception/branch kill)
- hi  out  32  HI register
- lo  out  32  LO register
- rdata  out  32  MFHI→hi, MFLO→lo, otherwise 0 (combinational)
- busy  out  1  state != IDLE
- stall  out  1  hold ID/EX and earlier stages
- done  out  1  one-cycle pulse after HI/LO written by mult/div

Behaviour:
- Reset (rst=0, async): hi=0, lo=0, state=IDLE, counter=0, busy=0, done=0; stall and rdata follow from these values.
- Decoding:
  - hilo_op = in_valid & inst_name in OP_MULT..OP_MTLO.
  - start = in_valid & !busy & !flush & inst_name in {MULT, MULTU, DIV, DIVU}.
- stall = busy & hilo_op, combinational. Non-HI/LO instructions never stall.
- MTHI/MTLO:
  - Take effect only when !busy & !flush.
  - HI or LO <= readData1 at that edge; no busy cycles.
- States: IDLE, MUL, DIV, FIX.
  - IDLE→MUL on start with MULT/MULTU.
  - IDLE→DIV on start with DIV/DIVU.
  - MUL→FIX and DIV→FIX after counter reaches 31 (32 iteration cycles).
  - FIX→IDLE always.
- Accept edge:
  - Latch |rs| and |rt| (signed ops) or raw values (unsigned ops).
  - Latch result sign flags: quotient/product sign = rs[31]^rt[31]; remainder sign = rs[31]; both signed ops only.
  - counter=0.
- MUL: radix-2 shift-add over 64-bit accumulator, one multiplier bit per cycle.
- DIV: restoring radix-2, one quotient bit per cycle, 33-bit partial remainder.
- FIX:
  - Apply two's-complement sign correction.
  - Write hi/lo at the edge leaving FIX.
  - done=1 for the following cycle.
- Results:
  - Mult: {hi,lo} = full 64-bit product.
  - Div: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
- Latency: busy high for exactly 33 cycles (32 iteration + FIX); hi/lo visible in the cycle done=1.
- Divide by zero:
  - Detected at accept; state→FIX directly (busy 1 cycle).
  - Result: hi=rs, lo=32'hFFFFFFFF.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- flush:
  - While busy: state→IDLE next edge, hi/lo unchanged, done stays 0.
  - flush in the same cycle as a would-be start: no accept.
- Start while busy is impossible: stall holds the instruction.
- Back-to-back: a new mult/div may be accepted in the cycle done=1.
- MFHI/MFLO in the done cycle reads the new values (no stall).

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN
- Defined:
  - MULT/MULTU compute the 64-bit product with a single-cycle multiplier at the accept edge.
  - Next state FIX; busy 1 cycle; hi/lo written at the edge leaving FIX.
  - State MUL is unreachable.
- Undefined: iterative 33-cycle multiply as above.
- Divide path is identical in both builds.

Test Plan:
- Reset mid-divide: DIV 100/7, assert rst=0 at cycle 10 → hi=lo=0, busy=0 immediately; after release MFLO returns 0.
- MULT rs=0xFFFFFFFE(-2), rt=3 → 33 busy cycles (1 with MULDIV_FAST_MUL_EN); hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once; MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7, rt=2 → lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU rs=7, rt=2 → lo=3, hi=1; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV rs=0x1234, rt=0 → busy exactly 1 cycle; hi=0x1234, lo=0xFFFFFFFF.
- MFLO in EX during a DIV → stall=1 every busy cycle; an ADD presented instead → stall=0; MFLO issued in the done cycle → rdata = new lo.
- flush at busy cycle 5 of MULT with prior hi=0xA, lo=0xB → busy=0 next cycle, hi/lo remain 0xA/0xB, done never asserts; MTHI rs=0x55 when idle → hi=0x55 next cycle, busy stays 0.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit sitting at the EX end of ID/EX.
// Build option MULDIV_FAST_MUL_EN: single-cycle multiplier for MULT/MULTU.
module ex_muldiv #(
  parameter logic [7:0] OP_MULT  = 8'h20,
  parameter logic [7:0] OP_MULTU = 8'h21,
  parameter logic [7:0] OP_DIV   = 8'h22,
  parameter logic [7:0] OP_DIVU  = 8'h23,
  parameter logic [7:0] OP_MFHI  = 8'h24,
  parameter logic [7:0] OP_MFLO  = 8'h25,
  parameter logic [7:0] OP_MTHI  = 8'h26,
  parameter logic [7:0] OP_MTLO  = 8'h27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  inst_name,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi, r_lo;
  logic        r_done;
  logic [63:0] r_acc;
  logic [31:0] r_rem, r_opb;
  logic        r_neg_q, r_neg_r, r_is_div;

  function automatic logic [31:0] abs32(input logic signed [31:0] v, input logic sgn);
    return (sgn && v < 0) ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] fix32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] fix64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  logic        w_hilo_op, w_is_md, w_is_div_op, w_signed, w_start, w_dbz;
  logic        w_busy, w_fix_wr, w_mt_ok;
  logic [31:0] w_abs_rs, w_abs_rt;
  logic [32:0] w_sum, w_shift, w_trial;

  assign w_hilo_op   = in_valid && (inst_name >= OP_MULT) && (inst_name <= OP_MTLO);
  assign w_is_div_op = (inst_name == OP_DIV) || (inst_name == OP_DIVU);
  assign w_is_md     = w_is_div_op || (inst_name == OP_MULT) || (inst_name == OP_MULTU);
  assign w_signed    = (inst_name == OP_MULT) || (inst_name == OP_DIV);
  assign w_busy      = (r_state != S_IDLE);
  assign w_start     = in_valid && !w_busy && !flush && w_is_md;
  assign w_dbz       = w_is_div_op && (readData2 == 32'd0);
  assign w_mt_ok     = in_valid && !w_busy && !flush;
  assign w_fix_wr    = (r_state == S_FIX) && !flush;
  assign w_abs_rs    = abs32(readData1, w_signed);
  assign w_abs_rt    = abs32(readData2, w_signed);

  // Shift-add step: conditionally add multiplicand into the upper half, then shift right
  assign w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
  // Restoring divide step on the 33-bit partial remainder
  assign w_shift = {r_rem, r_acc[31]};
  assign w_trial = w_shift - {1'b0, r_opb};

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] w_prod;
  assign w_prod = {32'd0, w_abs_rs} * {32'd0, w_abs_rt};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) begin
        if (w_is_div_op) w_next = w_dbz ? S_FIX : S_DIV;
        else begin
`ifdef MULDIV_FAST_MUL_EN
          w_next = S_FIX;
`else
          w_next = S_MUL;
`endif
        end
      end
      S_MUL, S_DIV: if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:        w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    if (flush && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_comb begin
    busy  = w_busy;
    stall = w_busy && w_hilo_op;
    rdata = 32'd0;
    if (inst_name == OP_MFHI)      rdata = r_hi;
    else if (inst_name == OP_MFLO) rdata = r_lo;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= 5'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix_wr;
      if (w_start) r_cnt <= 5'd0;
      else if (r_state == S_MUL || r_state == S_DIV) r_cnt <= r_cnt + 5'd1;
      if (w_fix_wr) begin
        if (r_is_div) begin
          r_hi <= fix32(r_rem, r_neg_r);
          r_lo <= fix32(r_acc[31:0], r_neg_q);
        end else begin
          {r_hi, r_lo} <= fix64(r_acc, r_neg_q);
        end
      end else if (w_mt_ok && inst_name == OP_MTHI) begin
        r_hi <= readData1;
      end else if (w_mt_ok && inst_name == OP_MTLO) begin
        r_lo <= readData1;
      end
    end
  end

  // Operand/accumulator datapath carries no reset; it is always loaded at accept
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_is_div <= w_is_div_op;
      r_opb    <= w_abs_rt;
      r_neg_q  <= w_signed && !w_dbz && (readData1[31] ^ readData2[31]);
      r_neg_r  <= w_signed && !w_dbz && readData1[31];
      r_rem    <= 32'd0;
      if (w_dbz) begin
        r_acc <= {32'd0, 32'hFFFF_FFFF};
        r_rem <= readData1;
      end else if (w_is_div_op) begin
        r_acc <= {32'd0, w_abs_rs};
      end else begin
`ifdef MULDIV_FAST_MUL_EN
        r_acc <= w_prod;
`else
        r_acc <= {32'd0, w_abs_rs};
`endif
      end
    end else if (r_state == S_MUL) begin
      r_acc <= {w_sum, r_acc[31:1]};
    end else if (r_state == S_DIV) begin
      r_rem        <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
      r_acc[31:0]  <= {r_acc[30:0], ~w_trial[32]};
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

endmodule
